// File: rtl/pcm_frame_feeder_if.sv
// Mixer-to-feeder sample handshake: one signed 16-bit left/right pair per
// accepted transfer (in_valid && in_ready).
interface pcm_frame_feeder_if;
    logic signed [15:0] in_left;
    logic signed [15:0] in_right;
    logic               in_valid;
    logic               in_ready;

    modport master (
        output in_left,
        output in_right,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_left,
        input  in_right,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/pcm_frame_feeder.sv
// pcm_frame_feeder: sample-pair FIFO plus frame-aligned feeder for the stereo
// PCM serializer. One pair is popped at frame_cnt == 30 so the serializer's
// frame-boundary load (count 31) captures a value that is stable for the
// whole frame. Underruns are counted (saturating) and flagged (sticky).
// Optional build macro PCM_FEEDER_HOLD_LAST_EN: on underrun, keep presenting
// the previous valid pair instead of forcing silence.
module pcm_frame_feeder #(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                bit_clock_in,
    input  logic                rst_active_high,
    pcm_frame_feeder_if.slave   in_if,
    input  logic                stream_en,
    input  logic                underrun_clear,
    output logic signed [15:0]  pcm_data_left,
    output logic signed [15:0]  pcm_data_right,
    output logic                pcm_data_valid,
    output logic [LVL_W-1:0]    fifo_level,
    output logic [15:0]         underrun_count,
    output logic                underrun_flag
);
    localparam int         PTR_W    = $clog2(DEPTH);
    localparam logic [4:0] TICK_CNT = 5'd30;

    // Saturating increment for the underrun event counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [31:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [4:0]         frame_cnt_q, frame_cnt_d;
    logic signed [15:0] left_q, left_d;
    logic signed [15:0] right_q, right_d;
    logic               valid_q, valid_d;
    logic [15:0]        underrun_count_q, underrun_count_d;
    logic               underrun_flag_q, underrun_flag_d;

    logic        full, empty, push, pop, frame_tick, underrun;
    logic [31:0] head;

    assign full       = (level_q == LVL_W'(DEPTH));
    assign empty      = (level_q == '0);
    assign frame_tick = (frame_cnt_q == TICK_CNT);
    assign push       = in_if.in_valid && in_if.in_ready;
    assign pop        = frame_tick && stream_en && !empty;
    assign underrun   = frame_tick && stream_en && empty;
    assign head       = mem_q[rd_ptr_q];

    // Ready is held low during reset and otherwise only reflects stored occupancy.
    assign in_if.in_ready = !full && !rst_active_high;

    assign pcm_data_left  = left_q;
    assign pcm_data_right = right_q;
    assign pcm_data_valid = valid_q;
    assign fifo_level     = level_q;
    assign underrun_count = underrun_count_q;
    assign underrun_flag  = underrun_flag_q;

    // Next-state for pointers, occupancy, frame counter, output pair and underrun status.
    always_comb begin
        wr_ptr_d         = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d         = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        frame_cnt_d      = frame_cnt_q + 5'd1;
        level_d          = level_q;
        left_d           = left_q;
        right_d          = right_q;
        valid_d          = valid_q;
        underrun_count_d = underrun_count_q;
        underrun_flag_d  = underrun_flag_q;

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (frame_tick) begin
            if (!stream_en) begin
                left_d  = '0;
                right_d = '0;
                valid_d = 1'b0;
            end else if (!empty) begin
                left_d  = head[31:16];
                right_d = head[15:0];
                valid_d = 1'b1;
            end else begin
`ifdef PCM_FEEDER_HOLD_LAST_EN
                // Keep the last real pair; silence only if nothing valid was shown.
                if (!valid_q) begin
                    left_d  = '0;
                    right_d = '0;
                end
`else
                left_d  = '0;
                right_d = '0;
                valid_d = 1'b0;
`endif
            end
        end

        // A clear on the same edge as an underrun takes priority.
        if (underrun_clear) begin
            underrun_count_d = '0;
            underrun_flag_d  = 1'b0;
        end else if (underrun) begin
            underrun_count_d = sat_inc16(underrun_count_q);
            underrun_flag_d  = 1'b1;
        end
    end

    // Control and output state registers, asynchronously cleared.
    always_ff @(posedge bit_clock_in or posedge rst_active_high) begin
        if (rst_active_high) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            frame_cnt_q      <= '0;
            left_q           <= '0;
            right_q          <= '0;
            valid_q          <= 1'b0;
            underrun_count_q <= '0;
            underrun_flag_q  <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            frame_cnt_q      <= frame_cnt_d;
            left_q           <= left_d;
            right_q          <= right_d;
            valid_q          <= valid_d;
            underrun_count_q <= underrun_count_d;
            underrun_flag_q  <= underrun_flag_d;
        end
    end

    // Sample storage; contents are meaningless after reset since the pointers restart.
    always_ff @(posedge bit_clock_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_if.in_left, in_if.in_right};
        end
    end
endmodule

// File: tb/tb_pcm_frame_feeder.sv
// Scoreboard bench for pcm_frame_feeder (DEPTH = 8). The stimulus process
// pushes hand-computed expected states tagged with a cycle number; the monitor
// pops and compares them against the DUT outputs on that cycle.
module tb_pcm_frame_feeder;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stream_en;
    logic               underrun_clear;
    logic signed [15:0] pl, pr;
    logic               pv;
    logic [3:0]         lvl;
    logic [15:0]        ucnt;
    logic               uflag;

    pcm_frame_feeder_if bus();

    pcm_frame_feeder #(.DEPTH(8)) dut (
        .bit_clock_in    (clk),
        .rst_active_high (rst),
        .in_if           (bus),
        .stream_en       (stream_en),
        .underrun_clear  (underrun_clear),
        .pcm_data_left   (pl),
        .pcm_data_right  (pr),
        .pcm_data_valid  (pv),
        .fifo_level      (lvl),
        .underrun_count  (ucnt),
        .underrun_flag   (uflag)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; equals the DUT frame counter modulo 32.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        string       name;
        int          at;
        logic [15:0] l, r;
        logic        v;
        logic [3:0]  lvl;
        logic        rdy;
        logic [15:0] cnt;
        logic        flag;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   checks = 0;
    int   errors = 0;

    // Expected DUT output state, maintained by hand in the stimulus.
    logic [15:0] e_l, e_r, e_cnt;
    logic        e_v, e_flag;

    // Monitor: compare every expectation due on the current cycle.
    always @(negedge clk) begin
        #1;
        while (q.size() > 0 && q[0].at <= cyc) begin
            m = q.pop_front();
            checks++;
            if (m.at != cyc) begin
                errors++;
                $display("FAIL %s: check due at cycle %0d missed (now %0d)", m.name, m.at, cyc);
            end else if ({pl, pr, pv, lvl, bus.in_ready, ucnt, uflag} !==
                         {m.l, m.r, m.v, m.lvl, m.rdy, m.cnt, m.flag}) begin
                errors++;
                $display("FAIL %s cyc=%0d got l=%h r=%h v=%b lvl=%0d rdy=%b cnt=%h flag=%b want l=%h r=%h v=%b lvl=%0d rdy=%b cnt=%h flag=%b",
                         m.name, cyc, pl, pr, pv, lvl, bus.in_ready, ucnt, uflag,
                         m.l, m.r, m.v, m.lvl, m.rdy, m.cnt, m.flag);
            end
        end
    end

    task automatic expect_at(input string name, input int at, input int level, input logic rdy);
        exp_t e;
        e.name = name; e.at = at; e.l = e_l; e.r = e_r; e.v = e_v;
        e.lvl = 4'(level); e.rdy = rdy; e.cnt = e_cnt; e.flag = e_flag;
        q.push_back(e);
    endtask

    task automatic at(input int n);
        while (cyc != n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int n, input int level, input logic rdy);
        at(n);
        expect_at(name, n, level, rdy);
    endtask

    task automatic set_out(input logic [15:0] l, input logic [15:0] r, input logic v);
        e_l = l; e_r = r; e_v = v;
    endtask

    task automatic underrun_out();
`ifdef PCM_FEEDER_HOLD_LAST_EN
        if (!e_v) begin e_l = '0; e_r = '0; end
`else
        e_l = '0; e_r = '0; e_v = 1'b0;
`endif
    endtask

    // Present one pair for a single cycle (caller sits at a negedge).
    task automatic drive(input logic [15:0] l, input logic [15:0] r);
        bus.in_valid = 1'b1; bus.in_left = l; bus.in_right = r;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Assert reset at the current negedge, hold three cycles, release.
    task automatic do_reset();
        rst = 1'b1; bus.in_valid = 1'b0;
        set_out('0, '0, 1'b0); e_cnt = '0; e_flag = 1'b0;
        expect_at("in_reset", 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_at("after_release", 0, 0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_left = '0; bus.in_right = '0;
        stream_en = 1'b1; underrun_clear = 1'b0;
        set_out('0, '0, 1'b0); e_cnt = '0; e_flag = 1'b0;
        @(negedge clk);
        do_reset();

        // Single pair through the first frame.
        at(2); drive(16'h1234, 16'hABCD);
        chk("push_level", 3, 1, 1'b1);
        chk("pre_tick", 30, 1, 1'b1);
        set_out(16'h1234, 16'hABCD, 1'b1);
        chk("first_pop", 31, 0, 1'b1);
        e_cnt = 16'd1; e_flag = 1'b1; underrun_out();
        chk("underrun_1", 63, 0, 1'b1);

        // Burst of eight, then a rejected ninth.
        at(64);
        for (int i = 0; i < 8; i++) drive(16'(16'h1000 + i), 16'(16'h2000 + i));
        chk("full_ready", 72, 8, 1'b0);
        bus.in_valid = 1'b1; bus.in_left = 16'h0BAD; bus.in_right = 16'h0BAD;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("no_overfill", 75, 8, 1'b0);
        for (int k = 0; k < 5; k++) begin
            set_out(16'(16'h1000 + k), 16'(16'h2000 + k), 1'b1);
            chk("burst_order", 95 + 32 * k, 7 - k, 1'b1);
        end

        // Push on the pop edge with level 3.
        at(254); drive(16'h5555, 16'hAAAA);
        set_out(16'h1005, 16'h2005, 1'b1);
        chk("push_pop_same_edge", 255, 3, 1'b1);
        set_out(16'h1006, 16'h2006, 1'b1); chk("burst_order6", 287, 2, 1'b1);
        set_out(16'h1007, 16'h2007, 1'b1); chk("burst_order7", 319, 1, 1'b1);
        set_out(16'h5555, 16'hAAAA, 1'b1); chk("pushed_mid_pop", 351, 0, 1'b1);
        e_cnt = 16'd2; underrun_out();
        chk("underrun_2", 383, 0, 1'b1);

        // Push into an empty FIFO on the tick edge: no fall-through.
        at(414); drive(16'h7777, 16'h8888);
        e_cnt = 16'd3; underrun_out();
        chk("push_on_empty_tick", 415, 1, 1'b1);
        set_out(16'h7777, 16'h8888, 1'b1);
        chk("late_push_pop", 447, 0, 1'b1);

        // Reset mid-frame with four queued.
        at(448);
        for (int i = 0; i < 4; i++) drive(16'(16'h3000 + i), 16'(16'h4000 + i));
        chk("four_queued", 452, 4, 1'b1);
        at(465);
        do_reset();
        at(5); drive(16'h0F0F, 16'hF0F0);
        chk("post_reset_push", 6, 1, 1'b1);
        chk("post_reset_pre_tick", 30, 1, 1'b1);
        set_out(16'h0F0F, 16'hF0F0, 1'b1);
        chk("post_reset_first_tick", 31, 0, 1'b1);

        // Playback disabled for three frames with two queued.
        at(33);
        drive(16'h1111, 16'h2222);
        drive(16'h3333, 16'h4444);
        stream_en = 1'b0;
        set_out('0, '0, 1'b0);
        chk("muted_1", 63, 2, 1'b1);
        chk("muted_2", 95, 2, 1'b1);
        chk("muted_3", 127, 2, 1'b1);
        at(128); stream_en = 1'b1;
        set_out(16'h1111, 16'h2222, 1'b1); chk("reenable_first", 159, 1, 1'b1);
        set_out(16'h3333, 16'h4444, 1'b1); chk("reenable_second", 191, 0, 1'b1);
        e_cnt = 16'd1; e_flag = 1'b1; underrun_out();
        chk("underrun_after_mute", 223, 0, 1'b1);

        // Saturation: preload the counter near the top, then underrun twice.
        at(224);
        force dut.underrun_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.underrun_count_q;
        e_cnt = 16'hFFFF; underrun_out();
        chk("saturate_reach", 255, 0, 1'b1);
        chk("saturate_hold", 287, 0, 1'b1);

        // Clear on the same edge as an underrun wins.
        at(318); underrun_clear = 1'b1;
        @(negedge clk); underrun_clear = 1'b0;
        e_cnt = '0; e_flag = 1'b0; underrun_out();
        chk("clear_wins", 319, 0, 1'b1);
        e_cnt = 16'd1; e_flag = 1'b1;
        chk("count_after_clear", 351, 0, 1'b1);
        at(360); underrun_clear = 1'b1;
        @(negedge clk); underrun_clear = 1'b0;
        e_cnt = '0; e_flag = 1'b0;
        chk("plain_clear", 361, 0, 1'b1);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL drain: %0d expectations never checked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
